// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external montgomery_mul.
// Optional MONT_EXP_CONST_TIME_EN issues a MUL for every exponent bit, discarding it on zero bits.
module mont_exp_ctrl #(
  parameter int NBITS = 256,
  parameter int EBITS = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_p,
  input  logic [NBITS-1:0]       base,
  input  logic [EBITS-1:0]       exp,
  input  logic [$clog2(EBITS):0] exp_size,
  input  logic [NBITS-1:0]       m,
  input  logic [NBITS-1:0]       m_size,
  input  logic [NBITS-1:0]       r2,
  output logic                   mm_enable_p,
  output logic [NBITS-1:0]       mm_a,
  output logic [NBITS-1:0]       mm_b,
  output logic [NBITS-1:0]       mm_m,
  output logic [NBITS-1:0]       mm_m_size,
  input  logic [NBITS-1:0]       mm_y,
  input  logic                   mm_done_p,
  output logic [NBITS-1:0]       y,
  output logic                   busy,
  output logic                   done_irq_p
);
  localparam int CW = $clog2(EBITS) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic [2:0] {SP_CBASE, SP_CONE, SP_SQR, SP_MUL, SP_COUT} step_e;

  state_e           state_q;
  step_e            step_q;
  logic [NBITS-1:0] base_q, m_q, msz_q, r2_q, acc_q, base_m_q;
  logic [NBITS-1:0] a_q, b_q, mm_m_q, mm_msz_q, y_q;
  logic [EBITS-1:0] exp_q;
  logic [CW-1:0]    idx_q, esz_q;
  logic             mm_en_q, busy_q, done_q;

  logic [CW-1:0]    esz_clamp, idx_m1;
  logic             cur_bit, mul_issue, last_bit;

  assign esz_clamp = (exp_size > CW'(EBITS)) ? CW'(EBITS) : exp_size;
  // idx_q counts bits still to process; the bit under work is idx_q-1
  assign idx_m1    = idx_q - CW'(1);
  assign cur_bit   = |(exp_q & (EBITS'(1) << idx_m1));
  assign last_bit  = (idx_q == CW'(1));

`ifdef MONT_EXP_CONST_TIME_EN
  assign mul_issue = 1'b1;
`else
  assign mul_issue = cur_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      step_q   <= SP_CBASE;
      base_q   <= '0;
      m_q      <= '0;
      msz_q    <= '0;
      r2_q     <= '0;
      acc_q    <= '0;
      base_m_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mm_m_q   <= '0;
      mm_msz_q <= '0;
      y_q      <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      esz_q    <= '0;
      mm_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mm_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (enable_p) begin
          base_q  <= base;
          exp_q   <= exp;
          esz_q   <= esz_clamp;
          m_q     <= m;
          msz_q   <= m_size;
          r2_q    <= r2;
          idx_q   <= '0;
          step_q  <= SP_CBASE;
          busy_q  <= 1'b1;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          mm_en_q  <= 1'b1;
          mm_m_q   <= m_q;
          mm_msz_q <= msz_q;
          case (step_q)
            SP_CBASE: begin a_q <= base_q;      b_q <= r2_q;       end
            SP_CONE:  begin a_q <= NBITS'(1);   b_q <= r2_q;       end
            SP_SQR:   begin a_q <= acc_q;       b_q <= acc_q;      end
            SP_MUL:   begin a_q <= acc_q;       b_q <= base_m_q;   end
            default:  begin a_q <= acc_q;       b_q <= NBITS'(1);  end
          endcase
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (mm_done_p) begin
          state_q <= ST_ISSUE;
          case (step_q)
            SP_CBASE: begin
              base_m_q <= mm_y;
              step_q   <= SP_CONE;
            end
            SP_CONE: begin
              acc_q <= mm_y;
              if (esz_q == '0) step_q <= SP_COUT;
              else begin
                idx_q  <= esz_q;
                step_q <= SP_SQR;
              end
            end
            SP_SQR: begin
              acc_q <= mm_y;
              if (mul_issue)     step_q <= SP_MUL;
              else if (last_bit) begin idx_q <= '0;     step_q <= SP_COUT; end
              else               begin idx_q <= idx_m1; step_q <= SP_SQR;  end
            end
            SP_MUL: begin
              if (cur_bit) acc_q <= mm_y;
              if (last_bit) begin idx_q <= '0;     step_q <= SP_COUT; end
              else          begin idx_q <= idx_m1; step_q <= SP_SQR;  end
            end
            default: begin
              y_q     <= mm_y;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              step_q  <= SP_CBASE;
              state_q <= ST_IDLE;
            end
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mm_enable_p = mm_en_q;
  assign mm_a        = a_q;
  assign mm_b        = b_q;
  assign mm_m        = mm_m_q;
  assign mm_m_size   = mm_msz_q;
  assign y           = y_q;
  assign busy        = busy_q;
  assign done_irq_p  = done_q;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: bit-serial Montgomery multiplier stand-in with random latency,
// reference result by repeated modular multiplication.
module tb_mont_exp_ctrl;
  localparam int NB = 32;
  localparam int EB = 16;
  localparam int CW = $clog2(EB) + 1;

  logic          clk = 1'b0;
  logic          rst_n, enable_p, spur;
  logic [NB-1:0] base, m, m_size, r2, mm_a, mm_b, mm_m, mm_m_size, mm_y, y;
  logic [EB-1:0] exp;
  logic [CW-1:0] exp_size;
  logic          mm_enable_p, mm_done_p, busy, done_irq_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk(clk), .rst_n(rst_n), .enable_p(enable_p), .base(base), .exp(exp),
    .exp_size(exp_size), .m(m), .m_size(m_size), .r2(r2),
    .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_m_size(mm_m_size), .mm_y(mm_y), .mm_done_p(mm_done_p),
    .y(y), .busy(busy), .done_irq_p(done_irq_p)
  );

  // a*b*2^-s mod m, radix-2 Montgomery
  function automatic longint mont(input longint a, input longint b, input longint mm, input int s);
    longint t;
    t = 0;
    for (int i = 0; i < s; i++) begin
      if (((a >> i) & 1) != 0) t += b;
      if ((t & 1) != 0) t += mm;
      t = t >>> 1;
    end
    if (t >= mm) t -= mm;
    return t;
  endfunction

  logic          mb, mult_done;
  logic [NB-1:0] ca, cb, cm, cs, mult_y;
  int            lat;
  int            n_inv = 0, n_mdone = 0, n_done = 0, stab_fail = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb <= 1'b0; mult_done <= 1'b0; mult_y <= '0; lat <= 0;
      ca <= '0; cb <= '0; cm <= '0; cs <= '0;
    end else begin
      mult_done <= 1'b0;
      if (mm_enable_p && !mb) begin
        mb <= 1'b1; lat <= int'($urandom_range(1, 4));
        ca <= mm_a; cb <= mm_b; cm <= mm_m; cs <= mm_m_size;
        n_inv <= n_inv + 1;
      end else if (mb) begin
        if (lat == 1) begin
          mb <= 1'b0; mult_done <= 1'b1;
          mult_y <= NB'(mont(longint'(ca), longint'(cb), longint'(cm), int'(cs)));
        end else lat <= lat - 1;
      end
    end
  end

  assign mm_y      = mult_y;
  assign mm_done_p = mult_done | spur;

  always @(posedge clk) begin
    n_mdone <= n_mdone + int'(mult_done);
    n_done  <= n_done + int'(done_irq_p);
  end

  always @(negedge clk)
    if (rst_n && mb && (mm_a !== ca || mm_b !== cb || mm_m !== cm || mm_m_size !== cs))
      stab_fail <= stab_fail + 1;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run(input string tag, input longint b, input longint e, input int es,
                     input longint mm, input int ms, input int glitch);
    longint eff, ref_y, r2v;
    int esz, pc, exp_inv, inv0, dn0, st0, cyc;
    bit got;
    esz   = (es > EB) ? EB : es;
    eff   = e & ((longint'(1) << esz) - 1);
    ref_y = 1 % mm;
    for (longint k = 0; k < eff; k++) ref_y = (ref_y * b) % mm;
    pc = 0;
    for (int i = 0; i < esz; i++) pc += int'((eff >> i) & 1);
`ifdef MONT_EXP_CONST_TIME_EN
    exp_inv = 3 + 2 * esz;
`else
    exp_inv = 3 + esz + pc;
`endif
    r2v = ((longint'(1) << ms) * (longint'(1) << ms)) % mm;
    @(negedge clk);
    base = NB'(b); exp = EB'(e); exp_size = CW'(es); m = NB'(mm); m_size = NB'(ms); r2 = NB'(r2v);
    inv0 = n_inv; dn0 = n_done; st0 = stab_fail;
    enable_p = 1'b1;
    @(negedge clk);
    enable_p = 1'b0;
    chk({tag, "_busy"}, longint'(busy), 1);
    got = 0; cyc = 0;
    while (!got && cyc < 3000) begin
      if (glitch > 0 && cyc == glitch) begin
        enable_p = 1'b1; base = NB'((b + 1) % mm); exp = ~EB'(e);
      end else enable_p = 1'b0;
      @(negedge clk);
      cyc++;
      if (done_irq_p) got = 1;
    end
    enable_p = 1'b0;
    chk({tag, "_done_seen"}, longint'(got), 1);
    chk({tag, "_y"}, longint'(y), ref_y);
    chk({tag, "_busy_low"}, longint'(busy), 0);
    chk({tag, "_invocations"}, longint'(n_inv - inv0), longint'(exp_inv));
    chk({tag, "_operand_stable"}, longint'(stab_fail - st0), 0);
    @(negedge clk);
    chk({tag, "_pulse_width"}, longint'(done_irq_p), 0);
    chk({tag, "_done_count"}, longint'(n_done - dn0), 1);
  endtask

  int     ms, es, dn0, md0, inv0, cyc;
  longint mm, bb, ee;
  logic [NB-1:0] y0;

  initial begin
    rst_n = 1'b0; enable_p = 1'b0; spur = 1'b0;
    base = '0; exp = '0; exp_size = '0; m = '0; m_size = '0; r2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_y", longint'(y), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done_irq_p), 0);
    chk("rst_mm_en", longint'(mm_enable_p), 0);
    chk("rst_mm_a", longint'(mm_a), 0);
    chk("rst_mm_m", longint'(mm_m), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("plan_a",     123, 5,   3, 625, 10, 0);
    run("esz0",       123, 5,   0, 625, 10, 0);
    run("base0",      0,   1,   1, 625, 10, 0);
    run("pow2_255",   2,   255, 8, 625, 10, 0);
    run("exp0",       77,  0,   6, 625, 10, 0);
    run("clamp",      3,   16'hFFFF, EB + 5, 625, 10, 0);
    run("glitch",     123, 5,   3, 625, 10, 4);

    // spurious multiplier completion while idle
    y0 = y; inv0 = n_inv;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_busy", longint'(busy), 0);
    chk("spur_mm_en", longint'(mm_enable_p), 0);
    chk("spur_y", longint'(y), longint'(y0));
    chk("spur_inv", longint'(n_inv - inv0), 0);

    // reset after the 4th multiplier completion
    @(negedge clk);
    base = 2; exp = 255; exp_size = 8; m = 625; m_size = 10; r2 = 451;
    dn0 = n_done; md0 = n_mdone;
    enable_p = 1'b1;
    @(negedge clk);
    enable_p = 1'b0;
    cyc = 0;
    while (n_mdone - md0 < 4 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("rst_mid_reached", longint'(n_mdone - md0 >= 4), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", longint'(y), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_mm_en", longint'(mm_enable_p), 0);
    chk("arst_mm_a", longint'(mm_a), 0);
    chk("arst_mm_b", longint'(mm_b), 0);
    chk("arst_mm_msz", longint'(mm_m_size), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", longint'(n_done - dn0), 0);
    run("after_rst",  123, 5,   3, 625, 10, 0);

    for (int t = 0; t < 10; t++) begin
      ms = int'($urandom_range(4, 16));
      mm = longint'($urandom_range(0, (1 << (ms - 1)) - 1)) | (longint'(1) << (ms - 1)) | 1;
      bb = longint'($urandom) % mm;
      ee = longint'($urandom & 32'hFFFF);
      es = int'($urandom_range(0, EB + 3));
      run($sformatf("rnd%0d", t), bb, ee, es, mm, ms, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
